// File: rtl/bin_to_bcd_seq_if.sv
// Conversion request/result bundle between a display client and bin_to_bcd_seq.
// The client drives start/bin/pause and observes the handshake and packed BCD result.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  pause;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  modport master (
    output start, bin, pause,
    input  busy, done, bcd, ovf
  );

  modport slave (
    input  start, bin, pause,
    output busy, done, bcd, ovf
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD encoder feeding the 7-segment digit decoders.
// Results saturate at all-nines with ovf; a latched pause shows the all-F pause glyph.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(pow10(DIGITS) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } stateT;

  stateT             state;
  logic [BIN_W-1:0]  binCap;
  logic [BIN_W-1:0]  binSr;
  logic              pauseLatched;
  logic [ACC_W-1:0]  accR;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  adjAcc;
  logic              busyR;
  logic              doneR;
  logic [ACC_W-1:0]  bcdR;
  logic              ovfR;

  // Add-3 correction on every digit that would exceed 9 after the next doubling.
  always_comb begin
    adjAcc = accR;
    for (int i = 0; i < DIGITS; i++) begin
      if (accR[4*i +: 4] >= 4'd5) begin
        adjAcc[4*i +: 4] = accR[4*i +: 4] + 4'd3;
      end
    end
  end

  // bcd/ovf are only written on the DONE edge so the display never sees partial sums.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      binCap       <= '0;
      binSr        <= '0;
      pauseLatched <= 1'b0;
      accR         <= '0;
      cnt          <= '0;
      busyR        <= 1'b0;
      doneR        <= 1'b0;
      bcdR         <= '0;
      ovfR         <= 1'b0;
    end else begin
      doneR <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            binCap       <= bus.bin;
            binSr        <= bus.bin;
            pauseLatched <= bus.pause;
            accR         <= '0;
            cnt          <= '0;
            busyR        <= 1'b1;
            state        <= SHIFT;
          end else begin
            busyR <= 1'b0;
          end
        end
        SHIFT: begin
          accR  <= {adjAcc[ACC_W-2:0], binSr[BIN_W-1]};
          binSr <= binSr << 1;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(BIN_W - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          doneR <= 1'b1;
          state <= IDLE;
          if (pauseLatched) begin
            bcdR <= {DIGITS{4'hF}};
            ovfR <= 1'b0;
          end else if (binCap > MAX_VAL) begin
            bcdR <= {DIGITS{4'h9}};
            ovfR <= 1'b1;
          end else begin
            bcdR <= accR;
            ovfR <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busyR <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busyR;
  assign bus.done = doneR;
  assign bus.bcd  = bcdR;
  assign bus.ovf  = ovfR;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: driver pushes decimal-model results, monitor pops on done.
// Also tracks busy timing, fixed latency, and that bcd/ovf hold between done pulses.
module tb_bin_to_bcd_seq;

  localparam int BIN_W   = 14;
  localparam int DIGITS  = 4;
  localparam int LATENCY = BIN_W + 1;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          acceptCycle;
  } expT;

  logic clock;
  logic rst;
  int   cycle;
  int   checks;
  int   errors;
  expT  expQ[$];
  int   acceptLog[$];
  logic [15:0] lastBcd;
  logic        lastOvf;

  bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk (clock),
    .rst (rst),
    .bus (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cycle = 0;
  always @(posedge clock) cycle = cycle + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Reference model: plain decimal arithmetic on the requested value.
  function automatic expT refModel(input int value, input bit p, input int acc);
    expT e;
    int  v;
    e.acceptCycle = acc;
    e.bcd = '0;
    e.ovf = 1'b0;
    if (p) begin
      e.bcd = 16'hFFFF;
    end else if (value > 9999) begin
      e.bcd = 16'h9999;
      e.ovf = 1'b1;
    end else begin
      v = value;
      for (int i = 0; i < DIGITS; i++) begin
        e.bcd[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return e;
  endfunction

  task automatic recordAccept(input int value, input bit p);
    expQ.push_back(refModel(value, p, cycle));
    acceptLog.push_back(cycle);
    if (acceptLog.size() > 2) void'(acceptLog.pop_front());
  endtask

  task automatic waitIdle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!bus.busy) begin
        idle = 1'b1;
        break;
      end
      @(posedge clock);
      #1;
    end
    if (!idle) checkOutput("waitIdleTimeout", 1, 0);
  endtask

  task automatic applyStimulus(input int value, input bit p);
    waitIdle();
    bus.bin   = BIN_W'(value);
    bus.pause = p;
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    recordAccept(value, p);
    bus.start = 1'b0;
    bus.bin   = BIN_W'($urandom);
    bus.pause = 1'($urandom);
  endtask

  // Monitor: sampled on the falling edge, decoupled from the driver.
  initial begin
    bit expBusy;
    int d;
    expT e;
    forever begin
      @(negedge clock);
      if (!rst) begin
        expBusy = 1'b0;
        foreach (acceptLog[k]) begin
          d = cycle - acceptLog[k];
          if (d >= 0 && d <= LATENCY) expBusy = 1'b1;
        end
        checkOutput("busy", int'(bus.busy), int'(expBusy));
        if (bus.done) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpectedDone", 1, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput("bcd", int'(bus.bcd), int'(e.bcd));
            checkOutput("ovf", int'(bus.ovf), int'(e.ovf));
            checkOutput("latency", cycle - e.acceptCycle, LATENCY);
          end
          lastBcd = bus.bcd;
          lastOvf = bus.ovf;
        end else begin
          checkOutput("bcdHold", int'(bus.bcd), int'(lastBcd));
          checkOutput("ovfHold", int'(bus.ovf), int'(lastOvf));
        end
      end
    end
  end

  initial begin
    int a;
    int v;
    bit p;
    checks  = 0;
    errors  = 0;
    lastBcd = '0;
    lastOvf = 1'b0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;
    bus.pause = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("resetBusy", int'(bus.busy), 0);
    checkOutput("resetDone", int'(bus.done), 0);
    checkOutput("resetBcd", int'(bus.bcd), 0);
    checkOutput("resetOvf", int'(bus.ovf), 0);
    rst = 1'b0;
    @(posedge clock);
    #1;

    $display("[TB] single conversion of 9999");
    applyStimulus(9999, 0);

    $display("[TB] back-to-back 0 then 1234 with start held");
    waitIdle();
    bus.bin   = 14'd0;
    bus.pause = 1'b0;
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    recordAccept(0, 0);
    bus.bin = 14'd1234;
    repeat (LATENCY + 1) @(posedge clock);
    #1;
    recordAccept(1234, 0);
    bus.start = 1'b0;
    bus.bin   = 14'd77;

    $display("[TB] overflow and recovery");
    applyStimulus(10000, 0);
    applyStimulus(16383, 0);
    applyStimulus(7, 0);

    $display("[TB] pause glyph");
    applyStimulus(42, 1);
    applyStimulus(42, 0);

    $display("[TB] starts while busy are ignored");
    waitIdle();
    bus.bin   = 14'd500;
    bus.pause = 1'b0;
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    recordAccept(500, 0);
    bus.start = 1'b0;
    bus.bin   = 14'd1;
    repeat (2) @(posedge clock);
    #1;
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    bus.start = 1'b1;
    bus.pause = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    bus.pause = 1'b0;

    $display("[TB] reset mid-conversion");
    waitIdle();
    bus.bin   = 14'd8888;
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    recordAccept(8888, 0);
    bus.start = 1'b0;
    repeat (6) @(posedge clock);
    #2;
    rst = 1'b1;
    expQ.delete();
    acceptLog.delete();
    lastBcd = '0;
    lastOvf = 1'b0;
    #1;
    checkOutput("abortBusy", int'(bus.busy), 0);
    checkOutput("abortDone", int'(bus.done), 0);
    checkOutput("abortBcd", int'(bus.bcd), 0);
    checkOutput("abortOvf", int'(bus.ovf), 0);
    repeat (3) @(posedge clock);
    #1;
    rst = 1'b0;
    repeat (LATENCY + 4) @(posedge clock);
    #1;
    applyStimulus(55, 0);

    $display("[TB] randomized conversions");
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0:       v = 9999 + int'($urandom_range(0, 2));
        1:       v = int'($urandom_range(10000, 16383));
        2:       v = int'($urandom_range(0, 99));
        default: v = int'($urandom_range(0, 9999));
      endcase
      p = ($urandom_range(0, 7) == 0);
      applyStimulus(v, p);
      a = int'($urandom_range(0, 3));
      repeat (a) @(posedge clock);
      #1;
    end

    for (int i = 0; i < 200 && expQ.size() != 0; i++) begin
      @(posedge clock);
      #1;
    end
    checkOutput("drainPending", expQ.size(), 0);
    repeat (5) @(posedge clock);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
